counter_timer_multi_wb: RTL

- Parametrised N-channel, WIDTH-bit counter/timer bank on Wishbone, shared prescaler; next generation of the single 32-bit counter/timer pair.
- Each channel counts up or down, in one-shot or continuous mode, and can chain to the previous channel's terminal strobe (arbitrary-width cascades).
- Adds per-channel input capture and a sticky write-1-to-clear IRQ status register.
- Sits on the management SoC Wishbone bus; one combined irq line goes to the CPU.

---
 rtl/counter_timer_pkg.sv | 30 +++
 rtl/counter_timer_channel.sv | 84 ++++++++
 rtl/counter_timer_multi_wb.sv | 138 +++++++++++++
 3 files changed

// File: rtl/counter_timer_pkg.sv
// Shared register map, CONFIG bit positions and byte-lane merge helper
// for the multi-channel counter/timer bank.
package counter_timer_pkg;
    localparam int CH_STRIDE = 16;

    localparam logic [3:0]  OFF_CFG        = 4'h0;
    localparam logic [3:0]  OFF_RELOAD     = 4'h4;
    localparam logic [3:0]  OFF_VALUE      = 4'h8;
    localparam logic [3:0]  OFF_CAPTURE    = 4'hC;
    localparam logic [31:0] OFF_IRQ_STATUS = 32'h100;
    localparam logic [31:0] OFF_PRESCALE   = 32'h104;

    localparam int CFG_EN      = 0;
    localparam int CFG_ONESHOT = 1;
    localparam int CFG_UP      = 2;
    localparam int CFG_CHAIN   = 3;
    localparam int CFG_IRQ     = 4;
    localparam int CFG_CAP     = 5;
    localparam int CFG_EDGE    = 6;
    localparam int CFG_W       = 7;

    function automatic logic [31:0] sel_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return res;
    endfunction
endpackage

// File: rtl/counter_timer_channel.sv
// One counter/timer channel: config, up/down counter with reload,
// terminal strobe and synchronised input capture.
module counter_timer_channel
    import counter_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_wr,
    input  logic [CFG_W-1:0] i_cfg_wdata,
    input  logic             i_reload_wr,
    input  logic [WIDTH-1:0] i_reload_wdata,
    input  logic             i_value_wr,
    input  logic [WIDTH-1:0] i_value_wdata,
    input  logic             i_evt,
    input  logic             i_cap_in,
    output logic [CFG_W-1:0] o_cfg,
    output logic [WIDTH-1:0] o_reload,
    output logic [WIDTH-1:0] o_value,
    output logic [WIDTH-1:0] o_capture,
    output logic             o_term_irq,
    output logic             o_cap_evt,
    output logic             o_strobe
);
    logic [CFG_W-1:0] r_cfg;
    logic [WIDTH-1:0] r_reload, r_value, r_capture;
    logic [1:0]       r_sync;
    logic             r_cap_prev, r_strobe;
    logic             w_en_rise, w_count, w_term, w_edge, w_cap;

    always_comb begin
        w_en_rise = i_cfg_wr & i_cfg_wdata[CFG_EN] & ~r_cfg[CFG_EN];
        // A bus write to VALUE or an enable edge swallows the count event.
        w_count   = r_cfg[CFG_EN] & i_evt & ~w_en_rise & ~i_value_wr;
        w_term    = w_count & (r_cfg[CFG_UP] ? (r_value == r_reload) : (r_value == '0));
        w_edge    = r_cfg[CFG_EDGE] ? (r_cap_prev & ~r_sync[1]) : (~r_cap_prev & r_sync[1]);
        w_cap     = w_edge & r_cfg[CFG_CAP];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cfg      <= '0;
            r_reload   <= '0;
            r_value    <= '0;
            r_capture  <= '0;
            r_sync     <= '0;
            r_cap_prev <= 1'b0;
            r_strobe   <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_cap_in};
            r_cap_prev <= r_sync[1];
            r_strobe   <= w_term;
            if (w_cap)
                r_capture <= r_value;
            if (i_reload_wr)
                r_reload <= i_reload_wdata;
            if (i_cfg_wr)
                r_cfg <= i_cfg_wdata;
            else if (w_term && r_cfg[CFG_ONESHOT])
                r_cfg[CFG_EN] <= 1'b0;
            if (i_value_wr)
                r_value <= i_value_wdata;
            else if (w_en_rise)
                r_value <= i_cfg_wdata[CFG_UP] ? '0 : r_reload;
            else if (w_count) begin
                if (w_term) begin
                    if (!r_cfg[CFG_ONESHOT])
                        r_value <= r_cfg[CFG_UP] ? '0 : r_reload;
                end else begin
                    r_value <= r_cfg[CFG_UP] ? r_value + WIDTH'(1) : r_value - WIDTH'(1);
                end
            end
        end
    end

    assign o_cfg      = r_cfg;
    assign o_reload   = r_reload;
    assign o_value    = r_value;
    assign o_capture  = r_capture;
    assign o_term_irq = w_term & r_cfg[CFG_IRQ];
    assign o_cap_evt  = w_cap;
    assign o_strobe   = r_strobe;
endmodule

// File: rtl/counter_timer_multi_wb.sv
// N-channel counter/timer bank on Wishbone: bus decode, shared prescaler,
// sticky W1C IRQ status and a registered combined irq.
module counter_timer_multi_wb
    import counter_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h2400_0000,
    parameter int          NUM_CH      = 4,
    parameter int          WIDTH       = 32,
    parameter int          PRESC_WIDTH = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic [31:0]       wb_dat_o,
    input  logic [NUM_CH-1:0] cap_in,
    output logic [NUM_CH-1:0] strobe_out,
    output logic              irq
);
    logic [31:0] w_off, w_word, w_rdata;
    logic [2:0]  w_ch;
    logic [3:0]  w_reg;
    logic        w_access, w_wr, w_chan_hit, w_stat_hit, w_presc_hit, w_tick;

    logic [NUM_CH-1:0][CFG_W-1:0] w_cfg;
    logic [NUM_CH-1:0][WIDTH-1:0] w_reload, w_value, w_capture;
    logic [NUM_CH-1:0]            w_evt, w_term_irq, w_cap_evt, w_strobe;

    logic                   r_ack, r_irq;
    logic [31:0]            r_dat;
    logic [PRESC_WIDTH-1:0] r_prescale, r_presc_cnt;
    logic [NUM_CH-1:0]      r_term_st, r_cap_st;

    assign w_access    = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr        = w_access & wb_we_i;
    assign w_off       = wb_adr_i - BASE_ADR;
    assign w_word      = {w_off[31:2], 2'b00};
    assign w_ch        = w_off[6:4];
    assign w_reg       = w_word[3:0];
    assign w_chan_hit  = w_off < 32'(NUM_CH * CH_STRIDE);
    assign w_stat_hit  = w_word == OFF_IRQ_STATUS;
    assign w_presc_hit = w_word == OFF_PRESCALE;
    assign w_tick      = r_presc_cnt == r_prescale;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_sel_ch;
        assign w_sel_ch = w_wr & w_chan_hit & (w_ch == 3'(c));
        // Chained channels count on the upstream strobe, one cycle late by design.
        if (c == 0) begin : g_first
            assign w_evt[c] = w_tick;
        end else begin : g_rest
            assign w_evt[c] = w_cfg[c][CFG_CHAIN] ? w_strobe[c-1] : w_tick;
        end

        counter_timer_channel #(.WIDTH(WIDTH)) u_ch (
            .i_clk          (wb_clk_i),
            .i_rst          (wb_rst_i),
            .i_cfg_wr       (w_sel_ch & (w_reg == OFF_CFG) & wb_sel_i[0]),
            .i_cfg_wdata    (wb_dat_i[CFG_W-1:0]),
            .i_reload_wr    (w_sel_ch & (w_reg == OFF_RELOAD)),
            .i_reload_wdata (WIDTH'(sel_merge(32'(w_reload[c]), wb_dat_i, wb_sel_i))),
            .i_value_wr     (w_sel_ch & (w_reg == OFF_VALUE)),
            .i_value_wdata  (WIDTH'(sel_merge(32'(w_value[c]), wb_dat_i, wb_sel_i))),
            .i_evt          (w_evt[c]),
            .i_cap_in       (cap_in[c]),
            .o_cfg          (w_cfg[c]),
            .o_reload       (w_reload[c]),
            .o_value        (w_value[c]),
            .o_capture      (w_capture[c]),
            .o_term_irq     (w_term_irq[c]),
            .o_cap_evt      (w_cap_evt[c]),
            .o_strobe       (w_strobe[c])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_chan_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_ch == 3'(c)) begin
                    case (w_reg)
                        OFF_CFG:     w_rdata = 32'(w_cfg[c]);
                        OFF_RELOAD:  w_rdata = 32'(w_reload[c]);
                        OFF_VALUE:   w_rdata = 32'(w_value[c]);
                        OFF_CAPTURE: w_rdata = 32'(w_capture[c]);
                        default:     w_rdata = '0;
                    endcase
                end
            end
        end else if (w_stat_hit) begin
            w_rdata[NUM_CH-1:0]  = r_term_st;
            w_rdata[8 +: NUM_CH] = r_cap_st;
        end else if (w_presc_hit) begin
            w_rdata = 32'(r_prescale);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_prescale  <= '0;
            r_presc_cnt <= '0;
            r_term_st   <= '0;
            r_cap_st    <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_ack <= w_access;
            if (w_access)
                r_dat <= w_rdata;
            if (w_wr && w_presc_hit) begin
                r_prescale  <= PRESC_WIDTH'(sel_merge(32'(r_prescale), wb_dat_i, wb_sel_i));
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_WIDTH'(1);
            end
            // New events win over a simultaneous write-1-to-clear.
            if (w_wr && w_stat_hit) begin
                r_term_st <= (r_term_st & ~wb_dat_i[NUM_CH-1:0]) | w_term_irq;
                r_cap_st  <= (r_cap_st & ~wb_dat_i[8 +: NUM_CH]) | w_cap_evt;
            end else begin
                r_term_st <= r_term_st | w_term_irq;
                r_cap_st  <= r_cap_st | w_cap_evt;
            end
            r_irq <= |{r_term_st, r_cap_st};
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat;
    assign strobe_out = w_strobe;
    assign irq        = r_irq;
endmodule
